// File: rtl/counter_pkg.sv
// Shared definitions for step_counter: direction encoding and parameter legality check.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Legal configuration: 2 <= modulo <= 2**dw and 1 <= step < modulo.
  function automatic bit params_ok(input int dw, input int step, input int modulo);
    longint lim;
    lim = longint'(1) << dw;
    return (dw >= 1) && (dw <= 31) && (modulo >= 2) && (longint'(modulo) <= lim) &&
           (step >= 1) && (step < modulo);
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-count and wrap for one enabled step of step_counter.
// STEP_COUNTER_SATURATE_EN selects clamp-at-boundary instead of modulo wrap-around.
module step_counter_next
  import counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STEP       = 1,
  parameter int MODULO     = 2**DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] count_i,
  input  logic                  down_i,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic                  wrap_o
);

  // One guard bit keeps MODULO = 2**DATA_WIDTH representable.
  localparam logic [DATA_WIDTH:0] STEP_X = (DATA_WIDTH+1)'(STEP);
  localparam logic [DATA_WIDTH:0] MOD_X  = (DATA_WIDTH+1)'(MODULO);
`ifdef STEP_COUNTER_SATURATE_EN
  localparam logic [DATA_WIDTH:0] MAX_X  = (DATA_WIDTH+1)'(MODULO - 1);
`endif

  logic [DATA_WIDTH:0] cnt_x;
  logic [DATA_WIDTH:0] sum_x;
  logic [DATA_WIDTH:0] nxt_x;

  always_comb begin
    cnt_x  = {1'b0, count_i};
    sum_x  = cnt_x + STEP_X;
    nxt_x  = cnt_x;
    wrap_o = 1'b0;
    if (down_i == DIR_UP) begin
      if (sum_x >= MOD_X) begin
        wrap_o = 1'b1;
`ifdef STEP_COUNTER_SATURATE_EN
        nxt_x  = MAX_X;
`else
        nxt_x  = sum_x - MOD_X;
`endif
      end else begin
        nxt_x = sum_x;
      end
    end else begin
      if (cnt_x >= STEP_X) begin
        nxt_x = cnt_x - STEP_X;
      end else begin
        wrap_o = 1'b1;
`ifdef STEP_COUNTER_SATURATE_EN
        nxt_x  = '0;
`else
        // cnt < STEP here, so the modular sum lands back inside [0, MODULO).
        nxt_x  = cnt_x + MOD_X - STEP_X;
`endif
      end
    end
    next_o = DATA_WIDTH'(nxt_x);
  end

endmodule

// File: rtl/step_counter.sv
// Modulo up/down counter with configurable step, sync clear/load and registered wrap/load_err.
// Build option STEP_COUNTER_SATURATE_EN: saturate at the range limits instead of wrapping.
module step_counter
  import counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STEP       = 1,
  parameter int MODULO     = 2**DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  en,
  input  logic                  down,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  wrap,
  output logic                  load_err
);

  if (!params_ok(DATA_WIDTH, STEP, MODULO)) begin : g_bad_params
    $error("step_counter: illegal DATA_WIDTH/STEP/MODULO combination");
  end

  localparam logic [DATA_WIDTH:0]   MOD_X = (DATA_WIDTH+1)'(MODULO);
  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MODULO - 1);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic                  load_err_q, load_err_d;
  logic [DATA_WIDTH-1:0] step_cnt;
  logic                  step_wrap;

  step_counter_next #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP),
    .MODULO     (MODULO)
  ) u_next (
    .count_i (count_q),
    .down_i  (down),
    .next_o  (step_cnt),
    .wrap_o  (step_wrap)
  );

  // clr > load > en > hold; the pulse outputs default low every cycle.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_X) begin
        count_d = load_val;
      end else begin
        count_d    = MAX_V;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      count_d = step_cnt;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
